move_compact_fifo: RTL and testbench
====================================

# move_compact_fifo

Parametrised move-collection FIFO. It is the successor to the fixed two-group move buffer behind each square unit. Each cycle it accepts up to LANES packed move words, discards words whose invalid flag is set, and compacts the survivors in lane order into a circular buffer. A downstream move arbiter drains it one move per cycle through a show-ahead read port. It adds backpressure, occupancy reporting, sticky overflow detection and a synchronous flush for new-board events.

## Interface
- MOVE_W, 19: move word width; format [flag 7b][from 6b][to 6b]; bit MOVE_W-1 is the invalid flag.
- LANES, 16: move slots presented per write.
- DEPTH, 64: storage entries; power of two, DEPTH >= LANES.
- AFULL, 48: almost-full threshold, 0..DEPTH.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush (new board); priority over read and write.
- wr_en  in  1  write request for wr_data.
- wr_data  in  LANES*MOVE_W  lane i at [i*MOVE_W +: MOVE_W]; lane i is valid iff its bit MOVE_W-1 is 0.
- wr_ready  out  1  (DEPTH - count) >= LANES; combinational from registered count.
- rd_en  in  1  pop the head entry.
- rd_valid  out  1  count != 0.
- rd_data  out  MOVE_W  head entry when rd_valid, else all zeros.
- count  out  clog2(DEPTH)+1  stored entries.
- afull  out  1  count >= AFULL.
- overflow  out  1  sticky; set by a rejected write.

## Operation
- Write accept: wr_en && wr_ready && !clr.
  - nvalid = number of lanes with flag bit MOVE_W-1 == 0; range 0..LANES.
  - Valid lanes are stored at wr_ptr, wr_ptr+1, … in ascending lane order (lowest lane first).
  - Invalid lanes are dropped and are never stored.
  - wr_ptr advances by nvalid, modulo DEPTH.
  - An accepted write with nvalid == 0 changes nothing.
- Rejected write: wr_en && !wr_ready && !clr.
  - Nothing is stored; pointers and count are unchanged.
  - overflow is set to 1 and stays set until clr or reset.
- Pop: rd_en && rd_valid && !clr.
  - rd_ptr advances by 1, modulo DEPTH.
  - rd_en with rd_valid = 0 is ignored; no state change.
- Count arithmetic: count_next = count + (accepted ? nvalid : 0) - (pop ? 1 : 0).
  - Computed at full width; never exceeds DEPTH and never goes below 0.
- Simultaneous write and pop:
  - Both take effect in the same cycle.
  - wr_ready is evaluated on the pre-pop count (conservative); a same-cycle pop never makes room for that cycle's write.
- Wrap-around: storage positions are (ptr + k) mod DEPTH. FIFO order across the wrap is preserved exactly.
- clr:
  - Zeros wr_ptr, rd_ptr, count and overflow.
  - Any same-cycle write or pop is discarded.
  - Memory contents are not cleared.
- Reset (reset_n low, at any time including mid-write):
  - Immediately zeros wr_ptr, rd_ptr, count and overflow.
  - Outputs become rd_valid=0, rd_data=0, count=0, afull=(AFULL==0), overflow=0, wr_ready=1.
  - Memory contents are not reset.
- Compaction is a prefix count over lane valid bits. Storage is a register array with per-entry write enables.

## Timing
- Write-to-read latency is 1 cycle: data accepted at edge N is visible on rd_data/rd_valid immediately after edge N.
- Read is show-ahead: rd_data is valid combinationally whenever rd_valid=1. After a pop at edge N, the next entry appears after edge N.
- count, afull and overflow are registered or derived from registered state; they update at the accepting/popping edge.
- wr_ready and rd_valid depend only on registered count; there is no combinational path from wr_en/rd_en.
- Sustained throughput: one LANES-wide write and one pop per cycle.

## Test plan
- Reset: hold reset_n=0 mid-stream with count=20, then release -> count=0, rd_valid=0, rd_data=0, wr_ready=1, overflow=0.
- Compaction order: one write with lane0=19'h00A43, lane3=19'h01F2C, lane15=19'h3E000, all other lanes flag=1 -> count=3; three pops return 00A43, 01F2C, 3E000, then rd_valid=0.
- Full and overflow: four writes of 16 valid lanes, no pops.
  - After the third write: count=48, afull=1, wr_ready=1.
  - After the fourth write: count=64, wr_ready=0.
  - A fifth wr_en -> overflow=1, count stays 64, the first popped value is still the first word written.
- Simultaneous: at count=10, write 5 valid lanes and pop in the same cycle -> count=14; the popped value is the old head.
- Wrap-around: write 60, pop 60, then write 16 distinct words (positions 60..63, 0..11) -> all 16 pop in written order with no loss.
- Flush: at count=30, overflow=1, assert clr together with wr_en (16 valid lanes) and rd_en -> next cycle count=0, overflow=0, rd_valid=0, wr_ready=1.

Source files
------------

// File: rtl/move_compact_fifo_if.sv
// -----------------------------------------------------------------------------
// move_compact_fifo_if
//
// Bundle of the write, read and flush signals of move_compact_fifo.
//   master : the producer/arbiter side (drives clr, wr_en, wr_data, rd_en)
//   slave  : the FIFO itself (drives wr_ready, rd_valid, rd_data, count,
//            afull, overflow)
//
// Signals:
//   clr       synchronous flush (new board)
//   wr_en     write request for wr_data
//   wr_data   LANES packed move words, lane i at [i*MOVE_W +: MOVE_W]
//   wr_ready  room for a full LANES-wide write
//   rd_en     pop the head entry
//   rd_valid  FIFO not empty
//   rd_data   head entry (zero when empty)
//   count     number of stored entries
//   afull     count >= AFULL
//   overflow  sticky flag, set by a rejected write
// -----------------------------------------------------------------------------
interface move_compact_fifo_if #(
    parameter int MOVE_W = 19,
    parameter int LANES  = 16,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    clr;
    logic                    wr_en;
    logic [LANES*MOVE_W-1:0] wr_data;
    logic                    wr_ready;
    logic                    rd_en;
    logic                    rd_valid;
    logic [MOVE_W-1:0]       rd_data;
    logic [CNT_W-1:0]        count;
    logic                    afull;
    logic                    overflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  wr_ready, rd_valid, rd_data, count, afull, overflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output wr_ready, rd_valid, rd_data, count, afull, overflow
    );
endinterface

// File: rtl/move_compact_fifo.sv
// -----------------------------------------------------------------------------
// move_compact_fifo
//
// Move-collection FIFO. Each cycle up to LANES packed move words are offered;
// words whose invalid flag (bit MOVE_W-1) is set are dropped and the survivors
// are packed, lowest lane first, into a circular buffer. The move arbiter
// drains one move per cycle through a show-ahead read port.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (pointers, count, overflow)
//   bus      move_compact_fifo_if.slave (write, read, flush and status)
// -----------------------------------------------------------------------------
module move_compact_fifo #(
    parameter int MOVE_W = 19,
    parameter int LANES  = 16,
    parameter int DEPTH  = 64,
    parameter int AFULL  = 48
) (
    input logic                 clk,
    input logic                 reset_n,
    move_compact_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [MOVE_W-1:0] word_t;

    // Storage and state
    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // Lane decode and compaction
    word_t            lane       [LANES];
    logic [LANES-1:0] lane_valid;
    logic [CNT_W-1:0] prefix     [LANES];
    logic [CNT_W-1:0] nvalid;

    // Per-entry write port
    logic [DEPTH-1:0] mem_we;
    word_t            mem_wdata  [DEPTH];

    // Handshake qualifiers
    logic [CNT_W-1:0] free_slots;
    logic             wr_ready;
    logic             rd_valid;
    logic             accept;
    logic             reject;
    logic             pop;

    // -------------------------------------------------------------------------
    // Prefix count over lane valid bits: prefix[i] is the number of valid lanes
    // below lane i, i.e. the offset from wr_ptr where lane i lands.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [CNT_W-1:0] run;
        // NOTE: every variable gets a value before any branch or loop so that
        // no path leaves it unassigned and no latch is inferred.
        run = '0;
        for (int i = 0; i < LANES; i++) begin
            lane[i]       = bus.wr_data[i*MOVE_W +: MOVE_W];
            lane_valid[i] = ~lane[i][MOVE_W-1];
            prefix[i]     = run;
            run           = run + CNT_W'(lane_valid[i]);
        end
        nvalid = run;
    end

    // Readiness is judged on the registered count only, so a same-cycle pop
    // never makes room for that cycle's write.
    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign wr_ready   = free_slots >= CNT_W'(LANES);
    assign rd_valid   = count_q != '0;

    assign accept = bus.wr_en &&  wr_ready && !bus.clr;
    assign reject = bus.wr_en && !wr_ready && !bus.clr;
    assign pop    = bus.rd_en &&  rd_valid && !bus.clr;

    // -------------------------------------------------------------------------
    // Entry e receives the valid lane whose prefix equals (e - wr_ptr) mod
    // DEPTH. Valid lanes have distinct prefixes, so at most one lane matches.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [PTR_W-1:0] offset;
        mem_we = '0;
        for (int e = 0; e < DEPTH; e++) begin
            mem_wdata[e] = '0;
            offset       = PTR_W'(e) - wr_ptr_q;
            for (int i = 0; i < LANES; i++) begin
                if (lane_valid[i] && (prefix[i] == {1'b0, offset})) begin
                    mem_we[e]    = accept;
                    mem_wdata[e] = lane[i];
                end
            end
        end
    end

    // NOTE: the storage array carries no reset; its contents are only ever
    // observed behind count, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (mem_we[e]) begin
                mem_q[e] <= mem_wdata[e];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: flush wins over everything; otherwise write and pop combine.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (bus.clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                // Truncation to PTR_W bits is the modulo-DEPTH wrap.
                wr_ptr_d = wr_ptr_q + PTR_W'(nvalid);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (accept ? nvalid : '0) - CNT_W'(pop);
            if (reject) begin
                overflow_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.count    = count_q;
    assign bus.afull    = count_q >= CNT_W'(AFULL);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_move_compact_fifo.sv
// -----------------------------------------------------------------------------
// tb_move_compact_fifo
//
// Self-checking bench for move_compact_fifo. A queue model holds the words the
// FIFO should contain; every pop compares the DUT head against the queue front
// and every cycle compares the status outputs against the model.
// -----------------------------------------------------------------------------
module tb_move_compact_fifo;
    localparam int MOVE_W = 19;
    localparam int LANES  = 16;
    localparam int DEPTH  = 64;
    localparam int AFULL  = 48;
    localparam int DW     = MOVE_W - 1;
    localparam int BUS_W  = LANES * MOVE_W;

    logic clk;
    logic reset_n;

    move_compact_fifo_if #(.MOVE_W(MOVE_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

    move_compact_fifo #(
        .MOVE_W (MOVE_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .AFULL  (AFULL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [MOVE_W-1:0] m_q [$];
    logic              m_ovf;
    logic [MOVE_W-1:0] last_pop;
    int                next_base;
    int                n_checks;
    int                n_errors;

    typedef struct {
        logic [LANES-1:0] mask;
        int               exp_n;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = m_q.size();
        check({tag, ".count"},    64'(bus.count),    64'(sz));
        check({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(sz != 0));
        check({tag, ".rd_data"},  64'(bus.rd_data),  (sz != 0) ? 64'(m_q[0]) : 64'd0);
        check({tag, ".wr_ready"}, 64'(bus.wr_ready), 64'((DEPTH - sz) >= LANES));
        check({tag, ".afull"},    64'(bus.afull),    64'(sz >= AFULL));
        check({tag, ".overflow"}, 64'(bus.overflow), 64'(m_ovf));
    endtask

    function automatic logic [BUS_W-1:0] mk(input logic [LANES-1:0] mask, input int base);
        logic [BUS_W-1:0] w;
        for (int i = 0; i < LANES; i++) begin
            w[i*MOVE_W +: MOVE_W] = mask[i] ? {1'b0, DW'(base + i)} : {1'b1, DW'($urandom)};
        end
        return w;
    endfunction

    // One clock: drive inputs, check the popped head, advance the model.
    task automatic cycle(input logic c, input logic we, input logic [BUS_W-1:0] wd,
                         input logic re);
        int   sz;
        logic acc, rej, pop;
        sz  = m_q.size();
        acc = we && !c && ((DEPTH - sz) >= LANES);
        rej = we && !c && !((DEPTH - sz) >= LANES);
        pop = re && !c && (sz != 0);
        bus.clr     = c;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        #1;
        if (pop) begin
            last_pop = bus.rd_data;
            check("pop_data", 64'(bus.rd_data), 64'(m_q[0]));
        end
        @(posedge clk);
        #1;
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                for (int i = 0; i < LANES; i++) begin
                    if (!wd[i*MOVE_W + MOVE_W - 1]) m_q.push_back(wd[i*MOVE_W +: MOVE_W]);
                end
            end
            if (rej) m_ovf = 1'b1;
        end
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_state("cyc");
    endtask

    task automatic write(input logic [LANES-1:0] mask, input logic re);
        cycle(1'b0, 1'b1, mk(mask, next_base), re);
        next_base += LANES;
    endtask

    task automatic pop_one();
        cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic flush();
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_q.size() != 0 && guard < DEPTH + 4) begin
            pop_one();
            guard++;
        end
        check("drain.empty", 64'(bus.rd_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs [6];
        logic [BUS_W-1:0] wd;

        n_checks  = 0;
        n_errors  = 0;
        m_ovf     = 1'b0;
        last_pop  = '0;
        next_base = 16'h0100;
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        reset_n     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset_n = 1'b1;

        // Table-driven compaction counts
        vecs[0] = '{16'h0000, 0};
        vecs[1] = '{16'hFFFF, 16};
        vecs[2] = '{16'h0001, 1};
        vecs[3] = '{16'h8000, 1};
        vecs[4] = '{16'hAAAA, 8};
        vecs[5] = '{16'h8009, 3};
        for (int v = 0; v < 6; v++) begin
            flush();
            write(vecs[v].mask, 1'b0);
            check($sformatf("vec%0d.count", v), 64'(bus.count), 64'(vecs[v].exp_n));
            drain();
        end

        // Asynchronous reset mid-stream at count=20
        write(16'hFFFF, 1'b0);
        write(16'h000F, 1'b0);
        check("pre_reset.count", 64'(bus.count), 64'd20);
        bus.wr_en   = 1'b1;
        bus.wr_data = mk(16'hFFFF, next_base);
        reset_n     = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        check_state("reset_mid");
        @(posedge clk);
        #1;
        check_state("reset_held");
        reset_n   = 1'b1;
        bus.wr_en = 1'b0;
        check("reset.count",    64'(bus.count),    64'd0);
        check("reset.wr_ready", 64'(bus.wr_ready), 64'd1);

        // Compaction order with the specified words
        wd = '0;
        for (int i = 0; i < LANES; i++) wd[i*MOVE_W +: MOVE_W] = {1'b1, DW'($urandom)};
        wd[0*MOVE_W +: MOVE_W]  = 19'h00A43;
        wd[3*MOVE_W +: MOVE_W]  = 19'h01F2C;
        wd[15*MOVE_W +: MOVE_W] = 19'h3E000;
        cycle(1'b0, 1'b1, wd, 1'b0);
        check("compact.count", 64'(bus.count), 64'd3);
        pop_one();
        check("compact.pop0", 64'(last_pop), 64'h00A43);
        pop_one();
        check("compact.pop1", 64'(last_pop), 64'h01F2C);
        pop_one();
        check("compact.pop2", 64'(last_pop), 64'h3E000);
        check("compact.empty", 64'(bus.rd_valid), 64'd0);

        // Full and overflow
        flush();
        next_base = 16'h1000;
        write(16'hFFFF, 1'b0);
        write(16'hFFFF, 1'b0);
        write(16'hFFFF, 1'b0);
        check("full3.count",    64'(bus.count),    64'd48);
        check("full3.afull",    64'(bus.afull),    64'd1);
        check("full3.wr_ready", 64'(bus.wr_ready), 64'd1);
        write(16'hFFFF, 1'b0);
        check("full4.count",    64'(bus.count),    64'd64);
        check("full4.wr_ready", 64'(bus.wr_ready), 64'd0);
        write(16'hFFFF, 1'b0);
        check("ovf.flag",  64'(bus.overflow), 64'd1);
        check("ovf.count", 64'(bus.count),    64'd64);
        pop_one();
        check("ovf.head", 64'(last_pop), 64'h1000);
        drain();
        check("ovf.sticky", 64'(bus.overflow), 64'd1);

        // Simultaneous write and pop at count=10
        flush();
        next_base = 16'h2000;
        write(16'h03FF, 1'b0);
        check("simul.pre", 64'(bus.count), 64'd10);
        write(16'h001F, 1'b1);
        check("simul.count", 64'(bus.count), 64'd14);
        check("simul.head",  64'(last_pop),  64'h2000);
        drain();

        // Wrap-around
        flush();
        write(16'hFFFF, 1'b0);
        write(16'hFFFF, 1'b0);
        write(16'hFFFF, 1'b0);
        write(16'h0FFF, 1'b0);
        check("wrap.fill", 64'(bus.count), 64'd60);
        drain();
        next_base = 16'h3000;
        write(16'hFFFF, 1'b0);
        check("wrap.count", 64'(bus.count), 64'd16);
        for (int k = 0; k < 16; k++) begin
            pop_one();
            if (k == 4) check("wrap.after_edge", 64'(last_pop), 64'h3004);
        end
        check("wrap.empty", 64'(bus.rd_valid), 64'd0);

        // Flush with a same-cycle write and pop at count=30, overflow=1
        flush();
        for (int k = 0; k < 5; k++) write(16'hFFFF, 1'b0);
        for (int k = 0; k < 34; k++) pop_one();
        check("flush.pre_count", 64'(bus.count),    64'd30);
        check("flush.pre_ovf",   64'(bus.overflow), 64'd1);
        cycle(1'b1, 1'b1, mk(16'hFFFF, next_base), 1'b1);
        check("flush.count",    64'(bus.count),    64'd0);
        check("flush.overflow", 64'(bus.overflow), 64'd0);
        check("flush.rd_valid", 64'(bus.rd_valid), 64'd0);
        check("flush.wr_ready", 64'(bus.wr_ready), 64'd1);

        // Random mix of sparse writes, pops and occasional flushes
        for (int n = 0; n < 300; n++) begin
            logic [LANES-1:0] mask;
            mask = LANES'($urandom & $urandom);
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                  mk(mask, next_base), $urandom_range(0, 2) != 0);
            next_base += LANES;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
